// File: rtl/microroc_sc_dac_loader_if.sv
// -----------------------------------------------------------------------------
// microroc_sc_dac_loader_if
// Bundles the load handshake, default-frame ROM port and ASIC slow-control
// serial lines of the Microroc DAC loader.
//
//   slave  : the loader itself
//            in : LoadSCParameter, OutDAC0[9:0], SCRomBit
//            out: MicrorocConfigDone, Busy, SCRomAddr[ADDR_W-1:0],
//                 SRIn, SRCk, SRRstb, Select
//   master : everything around it (sweep controller, ROM, ASIC)
// -----------------------------------------------------------------------------
interface microroc_sc_dac_loader_if #(
    parameter int ADDR_W = 10
);
    logic              LoadSCParameter;
    logic [9:0]        OutDAC0;
    logic              MicrorocConfigDone;
    logic              Busy;
    logic [ADDR_W-1:0] SCRomAddr;
    logic              SCRomBit;
    logic              SRIn;
    logic              SRCk;
    logic              SRRstb;
    logic              Select;

    modport slave (
        input  LoadSCParameter,
        input  OutDAC0,
        input  SCRomBit,
        output MicrorocConfigDone,
        output Busy,
        output SCRomAddr,
        output SRIn,
        output SRCk,
        output SRRstb,
        output Select
    );

    modport master (
        output LoadSCParameter,
        output OutDAC0,
        output SCRomBit,
        input  MicrorocConfigDone,
        input  Busy,
        input  SCRomAddr,
        input  SRIn,
        input  SRCk,
        input  SRRstb,
        input  Select
    );
endinterface

// File: rtl/microroc_sc_dac_loader.sv
// -----------------------------------------------------------------------------
// microroc_sc_dac_loader
// Responder to the sweep controller's LoadSCParameter request. Latches the
// requested DAC0 code, pulses the ASIC shift-register reset, then shifts a
// FRAME_BITS-long slow-control frame into the Microroc. The 10-bit DAC0 field
// (MSB first, starting at frame index DAC0_POS) comes from the latched code;
// every other bit comes from the external default-configuration ROM. A single
// MicrorocConfigDone pulse closes the transaction.
//
// Ports:
//   Clk   : system clock
//   reset : synchronous, active-high reset
//   sc    : microroc_sc_dac_loader_if.slave (handshake, ROM port, ASIC lines)
// -----------------------------------------------------------------------------
module microroc_sc_dac_loader #(
    parameter int FRAME_BITS = 592,
    parameter int DAC0_POS   = 0,
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                            Clk,
    input  logic                            reset,
    microroc_sc_dac_loader_if.slave         sc
);

    localparam int CW    = $clog2(FRAME_BITS);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [CW-1:0]    BIT_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0]    DAC_LO   = CW'(DAC0_POS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSTSR,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_FINISH,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [9:0]        r_dac;
    logic [CW-1:0]     r_bit_cnt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_srin;

    logic              w_div_last;
    logic              w_bit_last;
    logic [CW-1:0]     w_dac_off;
    logic              w_in_dac;
    logic [3:0]        w_dac_idx;
    logic              w_frame_bit;
    logic              w_busy;
    logic              w_srck;
    logic              w_srrstb;
    logic              w_done;

    assign w_div_last = (r_div_cnt == DIV_LAST);
    assign w_bit_last = (r_bit_cnt == BIT_LAST);

    // Offset into the DAC field. Indices below DAC0_POS wrap to a large
    // unsigned value, so a single upper-bound compare selects the field.
    assign w_dac_off   = r_bit_cnt - DAC_LO;
    assign w_in_dac    = (w_dac_off <= CW'(9));
    assign w_dac_idx   = 4'd9 - w_dac_off[3:0];
    assign w_frame_bit = w_in_dac ? r_dac[w_dac_idx] : sc.SCRomBit;

    // Next-state and Moore output decode.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_srck       = 1'b0;
        w_srrstb     = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (sc.LoadSCParameter) begin
                    w_state_next = ST_RSTSR;
                end
            end
            ST_RSTSR: begin
                w_srrstb = 1'b0;
                if (r_rst_cnt == RST_LAST) begin
                    w_state_next = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (w_div_last) begin
                    w_state_next = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                w_srck = 1'b1;
                if (w_div_last) begin
                    w_state_next = w_bit_last ? ST_FINISH : ST_SHIFT_LO;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dac      <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_rst_cnt  <= '0;
            r_rom_addr <= '0;
            r_srin     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (sc.LoadSCParameter) begin
                        r_dac      <= sc.OutDAC0;
                        r_bit_cnt  <= '0;
                        r_rst_cnt  <= '0;
                        // Address 0 is then held through the whole reset
                        // phase, so bit 0's ROM data is ready on entry to
                        // the first SHIFT_LO cycle.
                        r_rom_addr <= '0;
                    end
                end
                ST_RSTSR: begin
                    r_rst_cnt <= r_rst_cnt + RST_W'(1);
                    r_div_cnt <= '0;
                end
                ST_SHIFT_LO: begin
                    // ROM data for bit i is valid only in the first low cycle.
                    if (r_div_cnt == '0) begin
                        r_srin <= w_frame_bit;
                    end
                    if (w_div_last) begin
                        r_div_cnt  <= '0;
                        // Prefetch bit i+1; held through SHIFT_HI so the ROM
                        // answers in the next bit's first low cycle.
                        r_rom_addr <= ADDR_W'(r_bit_cnt) + ADDR_W'(1);
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_div_last) begin
                        r_div_cnt <= '0;
                        if (w_bit_last) begin
                            r_srin <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sc.MicrorocConfigDone = w_done;
    assign sc.Busy               = w_busy;
    assign sc.Select             = w_busy;
    assign sc.SRCk               = w_srck;
    assign sc.SRRstb             = w_srrstb;
    assign sc.SRIn               = r_srin;
    assign sc.SCRomAddr          = r_rom_addr;

endmodule

// File: tb/tb_microroc_sc_dac_loader.sv
// Directed bench: 16-bit frame, DAC field at bits 4..13, ROM = 1 on even
// addresses and 0 on odd ones. Expected frames are hand-computed constants.
module tb_microroc_sc_dac_loader;
    localparam int FRAME_BITS = 16;
    localparam int DAC0_POS   = 4;
    localparam int CLK_DIV    = 2;
    localparam int RST_CYCLES = 4;
    localparam int ADDR_W     = 10;
    localparam int DONE_LAT   = 70;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    microroc_sc_dac_loader_if #(.ADDR_W(ADDR_W)) sc_if ();

    microroc_sc_dac_loader #(
        .FRAME_BITS (FRAME_BITS),
        .DAC0_POS   (DAC0_POS),
        .CLK_DIV    (CLK_DIV),
        .RST_CYCLES (RST_CYCLES),
        .ADDR_W     (ADDR_W)
    ) u_dut (
        .Clk   (clk),
        .reset (reset),
        .sc    (sc_if.slave)
    );

    // Default-frame ROM with one cycle of read latency.
    always @(posedge clk) sc_if.SCRomBit <= ~sc_if.SCRomAddr[0];

    // Issues a load in cycle 0 and observes cycles 1..; optional second load
    // (inj_load) and reset (inj_rst) are applied at the given cycles.
    task automatic run_frame(input logic [9:0] dac, input logic [9:0] inj_dac,
                             input int inj_load, input int inj_rst, input int extra,
                             output logic [15:0] bits, output int n_edges,
                             output int done_at, output int n_done,
                             output int rstb_low, output int busy_cnt,
                             output logic [3:0] snap);
        logic prev_srck;
        int   lim;
        bits = '0; n_edges = 0; done_at = -1; n_done = 0;
        rstb_low = 0; busy_cnt = 0; snap = '0; prev_srck = 1'b0;
        lim = 150 + extra;
        @(negedge clk);
        sc_if.LoadSCParameter = 1'b1;
        sc_if.OutDAC0         = dac;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            if (k == 1 || k == inj_load + 1) sc_if.LoadSCParameter = 1'b0;
            if (k == inj_rst + 1) begin
                reset = 1'b0;
                snap  = {sc_if.SRCk, sc_if.SRRstb, sc_if.Busy, sc_if.MicrorocConfigDone};
            end
            if (sc_if.SRCk && !prev_srck) begin
                if (n_edges < 16) bits[n_edges] = sc_if.SRIn;
                n_edges++;
            end
            prev_srck = sc_if.SRCk;
            if (!sc_if.SRRstb) rstb_low++;
            if (sc_if.Busy) busy_cnt++;
            if (sc_if.MicrorocConfigDone) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (k == inj_load) begin
                sc_if.LoadSCParameter = 1'b1;
                sc_if.OutDAC0         = inj_dac;
            end
            if (k == inj_rst) reset = 1'b1;
            if (done_at >= 0 && k >= done_at + extra) break;
        end
        $display("frame dac=%03h bits=%04h edges=%0d done_at=%0d dones=%0d rstb_low=%0d busy=%0d",
                 dac, bits, n_edges, done_at, n_done, rstb_low, busy_cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sc_if.LoadSCParameter = 1'b0;
        sc_if.OutDAC0 = 10'h000;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (sc_if.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", sc_if.Busy); end
        n_vec++; if (sc_if.MicrorocConfigDone !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", sc_if.MicrorocConfigDone); end
        n_vec++; if (sc_if.SRIn !== 1'b0) begin n_err++; $display("FAIL reset_srin got=%b exp=0", sc_if.SRIn); end
        n_vec++; if (sc_if.SRCk !== 1'b0) begin n_err++; $display("FAIL reset_srck got=%b exp=0", sc_if.SRCk); end
        n_vec++; if (sc_if.SRRstb !== 1'b1) begin n_err++; $display("FAIL reset_srrstb got=%b exp=1", sc_if.SRRstb); end
        n_vec++; if (sc_if.Select !== 1'b0) begin n_err++; $display("FAIL reset_select got=%b exp=0", sc_if.Select); end
        n_vec++; if (sc_if.SCRomAddr !== '0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", sc_if.SCRomAddr); end
        reset = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_idle_hold();
        int srck_hi = 0;
        int busy_hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sc_if.SRCk) srck_hi++;
            if (sc_if.Busy) busy_hi++;
        end
        n_vec++; if (srck_hi !== 0) begin n_err++; $display("FAIL idle_srck got=%0d exp=0", srck_hi); end
        n_vec++; if (busy_hi !== 0) begin n_err++; $display("FAIL idle_busy got=%0d exp=0", busy_hi); end
        $display("idle hold 20 cycles srck_hi=%0d busy_hi=%0d", srck_hi, busy_hi);
    endtask

    task automatic test_single_frame();
        logic [15:0] bits; logic [3:0] snap;
        int ne, da, nd, rl, bc;
        run_frame(10'h2A5, 10'h000, -5, -5, 0, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (da !== DONE_LAT) begin n_err++; $display("FAIL single_done_at got=%0d exp=%0d", da, DONE_LAT); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL single_n_done got=%0d exp=1", nd); end
        n_vec++; if (ne !== 16) begin n_err++; $display("FAIL single_edges got=%0d exp=16", ne); end
        n_vec++; if (rl !== 4) begin n_err++; $display("FAIL single_rstb_low got=%0d exp=4", rl); end
        n_vec++; if (bits !== 16'h6955) begin n_err++; $display("FAIL single_bits got=%04h exp=6955", bits); end
        n_vec++; if (bc !== 70) begin n_err++; $display("FAIL single_busy got=%0d exp=70", bc); end
    endtask

    task automatic test_ignored_load();
        logic [15:0] bits; logic [3:0] snap;
        int ne, da, nd, rl, bc;
        run_frame(10'h2A5, 10'h000, 30, -5, 80, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (da !== DONE_LAT) begin n_err++; $display("FAIL ignored_done_at got=%0d exp=%0d", da, DONE_LAT); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL ignored_n_done got=%0d exp=1", nd); end
        n_vec++; if (ne !== 16) begin n_err++; $display("FAIL ignored_edges got=%0d exp=16", ne); end
        n_vec++; if (bits !== 16'h6955) begin n_err++; $display("FAIL ignored_bits got=%04h exp=6955", bits); end
        n_vec++; if (bc !== 70) begin n_err++; $display("FAIL ignored_busy got=%0d exp=70", bc); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits; logic [3:0] snap;
        int ne, da, nd, rl, bc;
        run_frame(10'h000, 10'h000, -5, -5, 0, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (da !== DONE_LAT) begin n_err++; $display("FAIL b2b0_done_at got=%0d exp=%0d", da, DONE_LAT); end
        n_vec++; if (bits !== 16'h4005) begin n_err++; $display("FAIL b2b0_bits got=%04h exp=4005", bits); end
        run_frame(10'h3FF, 10'h000, -5, -5, 0, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (da !== DONE_LAT) begin n_err++; $display("FAIL b2b1_done_at got=%0d exp=%0d", da, DONE_LAT); end
        n_vec++; if (bits !== 16'h7FF5) begin n_err++; $display("FAIL b2b1_bits got=%04h exp=7ff5", bits); end
        n_vec++; if (ne !== 16) begin n_err++; $display("FAIL b2b1_edges got=%0d exp=16", ne); end
    endtask

    task automatic test_load_during_done();
        logic [15:0] bits; logic [3:0] snap;
        int ne, da, nd, rl, bc;
        run_frame(10'h155, 10'h2A5, 70, -5, 30, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (bits !== 16'h6AA5) begin n_err++; $display("FAIL donecyc_bits got=%04h exp=6aa5", bits); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL donecyc_n_done got=%0d exp=1", nd); end
        n_vec++; if (ne !== 16) begin n_err++; $display("FAIL donecyc_edges got=%0d exp=16", ne); end
        n_vec++; if (bc !== 70) begin n_err++; $display("FAIL donecyc_busy got=%0d exp=70", bc); end
        n_vec++; if (rl !== 4) begin n_err++; $display("FAIL donecyc_rstb_low got=%0d exp=4", rl); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits; logic [3:0] snap;
        int ne, da, nd, rl, bc;
        run_frame(10'h2A5, 10'h000, -5, 40, 0, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (snap !== 4'b0100) begin n_err++; $display("FAIL midrst_snap {srck,srrstb,busy,done} got=%b exp=0100", snap); end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL midrst_n_done got=%0d exp=0", nd); end
        n_vec++; if (ne !== 9) begin n_err++; $display("FAIL midrst_edges got=%0d exp=9", ne); end
        run_frame(10'h3FF, 10'h000, -5, -5, 0, bits, ne, da, nd, rl, bc, snap);
        n_vec++; if (da !== DONE_LAT) begin n_err++; $display("FAIL postrst_done_at got=%0d exp=%0d", da, DONE_LAT); end
        n_vec++; if (bits !== 16'h7FF5) begin n_err++; $display("FAIL postrst_bits got=%04h exp=7ff5", bits); end
    endtask

    initial begin
        sc_if.LoadSCParameter = 1'b0;
        sc_if.OutDAC0         = 10'h000;
        test_reset();
        test_idle_hold();
        test_single_frame();
        test_ignored_load();
        test_back_to_back();
        test_load_during_done();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/microroc_sc_dac_loader.md
Name: microroc_sc_dac_loader

Overview:
- Responder side of the sweep controller's slow-control handshake.
- On a LoadSCParameter request it latches the requested DAC0 code and builds the Microroc slow-control frame. DAC0 is inserted at a fixed field; every other bit comes from an external default-configuration ROM.
- It shifts the frame serially into the ASIC, then returns a one-cycle MicrorocConfigDone pulse so the sweep can start the next acquisition.

Parameters:
- FRAME_BITS, 592, total slow-control frame length in bits
- DAC0_POS, 0, frame index of the first (MSB) bit of the 10-bit DAC0 field; DAC0_POS+9 < FRAME_BITS
- CLK_DIV, 4, Clk cycles per SRCk half-period; minimum 2
- RST_CYCLES, 8, Clk cycles SRRstb is held low before shifting; minimum 1
- ADDR_W, 10, ROM address width; 2^ADDR_W >= FRAME_BITS

Ports:
- Clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- LoadSCParameter  in  1  load request; a 1-cycle pulse from the sweep controller
- OutDAC0  in  10  DAC0 code, sampled in the LoadSCParameter cycle
- MicrorocConfigDone  out  1  1-cycle pulse when the frame is fully shifted
- Busy  out  1  high from the cycle after an accepted load until the done cycle inclusive
- SCRomAddr  out  ADDR_W  default-frame ROM address (bit index)
- SCRomBit  in  1  ROM data; valid exactly 1 cycle after SCRomAddr
- SRIn  out  1  serial data to the ASIC
- SRCk  out  1  serial clock to the ASIC
- SRRstb  out  1  ASIC shift-register reset, active low
- Select  out  1  slow-control register select; high while Busy

Behaviour:
- Reset values (when reset=1 at a Clk edge): state IDLE, Busy=0, MicrorocConfigDone=0, SRIn=0, SRCk=0, SRRstb=1, Select=0, SCRomAddr=0. Reset mid-frame aborts immediately; no done pulse is produced.
- States are IDLE, RSTSR, SHIFT_LO, SHIFT_HI, FINISH, DONE.
- IDLE:
  - LoadSCParameter=1 latches OutDAC0 into DacReg, clears the bit counter, and goes to RSTSR.
  - LoadSCParameter while not IDLE is ignored; no queueing.
- RSTSR:
  - SRRstb=0 and Select=1 for exactly RST_CYCLES cycles.
  - SCRomAddr=0 is driven during the last RSTSR cycle.
  - Then go to SHIFT_LO with bit index i=0.
- SHIFT_LO, held CLK_DIV cycles:
  - SRCk=0.
  - In the 1st cycle, SCRomBit is valid for address i.
  - In the 2nd cycle, SRIn updates to the frame bit for i.
- Frame bit rule:
  - For DAC0_POS <= i <= DAC0_POS+9, frame bit = DacReg[9-(i-DAC0_POS)]. DAC0 is sent MSB first, and the ROM bit is discarded.
  - Otherwise frame bit = SCRomBit.
- SHIFT_HI, held CLK_DIV cycles:
  - SRCk=1; SRIn is stable (the ASIC samples on the SRCk rising edge).
  - SCRomAddr=i+1 is driven during the last SHIFT_HI cycle.
  - If i=FRAME_BITS-1, go to FINISH; else i<=i+1 and go to SHIFT_LO.
- FINISH: 1 cycle; SRCk=0, SRIn=0.
- DONE: 1 cycle; MicrorocConfigDone=1, Busy=1, Select=1; then IDLE with Busy=0 and Select=0.
- Latency: with the load sampled at cycle 0, the done pulse occurs at cycle RST_CYCLES + 2*CLK_DIV*FRAME_BITS + 2.
- Exactly FRAME_BITS SRCk rising edges are produced per load.
- Counters:
  - The bit counter is ceil(log2(FRAME_BITS)) bits wide and never wraps.
  - The divider counter is ceil(log2(CLK_DIV)) bits wide and reloads at each phase change.
- SRRstb=1 in every state except RSTSR.
- A load arriving in the same cycle as the DONE pulse is ignored. The controller issues its next load only after seeing the done pulse.

Test Plan:
- Use FRAME_BITS=16, DAC0_POS=4, CLK_DIV=2, RST_CYCLES=4, with the ROM returning 1 for even addresses and 0 for odd.
- Reset → all outputs at reset values; hold 20 cycles with no load → no SRCk edges, Busy=0.
- Load, OutDAC0=10'h2A5 → SRRstb low 4 cycles, 16 SRCk rising edges, done pulse exactly at cycle 70 relative to the load cycle.
- Bits captured on SRCk rising edges → 1,0,1,0, then 1,0,1,0,1,0,0,1,0,1, then 1,0.
- Second load issued at cycle 30 of a frame → ignored; one done pulse; frame unchanged.
- Loads with OutDAC0=0 then 10'h3FF back-to-back (second issued the cycle after done) → DAC field bits 4..13 captured as all 0, then all 1; ROM bits unchanged.
- reset asserted at cycle 40 of a frame → next cycle SRCk=0, SRRstb=1, Busy=0, no done pulse; a following load completes normally in 70 cycles.
